// File: rtl/fifo_rd_packer.sv
// Read-side packer for the async FIFO: issues reads, absorbs the one-cycle read latency and
// packs PACK_RATIO narrow words into one wide valid/ready word, with flush of partial words.
module fifo_rd_packer #(
   parameter int DATA_WIDTH = 8,
   parameter int PACK_RATIO = 4,
   parameter int CNT_W      = $clog2(PACK_RATIO + 1)
) (
   input  logic                             clk_i,
   input  logic                             rst_i,
   input  logic                             fifo_rrdy_i,
   output logic                             fifo_re_o,
   input  logic [DATA_WIDTH-1:0]            fifo_dout_i,
   input  logic                             flush_i,
   output logic                             m_valid_o,
   input  logic                             m_ready_i,
   output logic [DATA_WIDTH*PACK_RATIO-1:0] m_data_o,
   output logic [CNT_W-1:0]                 m_count_o
);

   localparam int WIDE = DATA_WIDTH * PACK_RATIO;
   localparam logic [CNT_W-1:0] FULL = CNT_W'(PACK_RATIO);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(PACK_RATIO - 1);

   typedef enum logic [1:0] {
      ACC,
      DRAIN,
      EMIT
   } state_t;

   state_t          state;
   state_t          state_next;
   logic [WIDE-1:0] acc;
   logic [WIDE-1:0] acc_cap;
   logic [WIDE-1:0] acc_next;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_cap;
   logic [CNT_W-1:0] cnt_next;
   logic [CNT_W:0]  fill;
   logic            pend;
   logic            out_free;
   logic            emit;
   logic            flush_take;
   logic            room;

   // acc_cap/cnt_cap are the accumulator after the landing word; emit empties it into the output
   always_comb begin
      out_free = ~m_valid_o | m_ready_i;
      acc_cap  = acc;
      for (int i = 0; i < PACK_RATIO; i++) begin
         if (pend && (cnt == CNT_W'(i))) begin
            acc_cap[i*DATA_WIDTH +: DATA_WIDTH] = fifo_dout_i;
         end
      end
      cnt_cap  = cnt + CNT_W'(pend);
      emit     = out_free & ((cnt_cap == FULL) | ((state == EMIT) & (cnt_cap != '0)));
      acc_next = emit ? '0 : acc_cap;
      cnt_next = emit ? '0 : cnt_cap;
   end

   // A read is allowed when its word will have a lane, counting a lane freed by this edge's transfer
   always_comb begin
      fill       = {1'b0, cnt} + (CNT_W + 1)'(pend);
      room       = (fill < (CNT_W + 1)'(PACK_RATIO)) | (pend & (cnt == LAST) & out_free);
      flush_take = flush_i & (state == ACC) & ((cnt != '0) | pend);
      fifo_re_o  = 1'b0;
      state_next = state;
      case (state)
         ACC: begin
            fifo_re_o = ~rst_i & ~flush_take & fifo_rrdy_i & room;
            if (flush_take) begin
               state_next = DRAIN;
            end
         end
         DRAIN: begin
            state_next = (cnt_next == '0) ? ACC : EMIT;
         end
         EMIT: begin
            if ((cnt == '0) || emit) begin
               state_next = ACC;
            end
         end
         default: state_next = ACC;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state <= ACC;
      end else begin
         state <= state_next;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         acc       <= '0;
         cnt       <= '0;
         pend      <= 1'b0;
         m_valid_o <= 1'b0;
         m_data_o  <= '0;
         m_count_o <= '0;
      end else begin
         acc  <= acc_next;
         cnt  <= cnt_next;
         pend <= fifo_re_o & fifo_rrdy_i;
         if (emit) begin
            m_valid_o <= 1'b1;
            m_data_o  <= acc_cap;
            m_count_o <= cnt_cap;
         end else if (m_ready_i) begin
            m_valid_o <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Directed bench for fifo_rd_packer (8-bit words, 4 lanes) with a small FIFO model
// that returns read data one cycle after an accepted read.
module tb_fifo_rd_packer;

   localparam int DW = 8;
   localparam int PR = 4;
   localparam int CW = $clog2(PR + 1);

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          fifo_rrdy;
   logic          fifo_re;
   logic [DW-1:0] fifo_dout = '0;
   logic          flush = 1'b0;
   logic          m_valid;
   logic          m_ready = 1'b1;
   logic [DW*PR-1:0] m_data;
   logic [CW-1:0] m_count;

   logic [DW-1:0] mem [0:63];
   int            wr_ptr = 0;
   int            rd_ptr = 0;
   int            rd_count = 0;
   logic          fifo_en = 1'b0;
   int            checks = 0;
   int            fails = 0;
   int            rd0;

   fifo_rd_packer #(
      .DATA_WIDTH(DW),
      .PACK_RATIO(PR)
   ) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .fifo_rrdy_i(fifo_rrdy),
      .fifo_re_o  (fifo_re),
      .fifo_dout_i(fifo_dout),
      .flush_i    (flush),
      .m_valid_o  (m_valid),
      .m_ready_i  (m_ready),
      .m_data_o   (m_data),
      .m_count_o  (m_count)
   );

   always #5 clk = ~clk;

   assign fifo_rrdy = fifo_en && (rd_ptr != wr_ptr);

   // FIFO model: reset drops all stored words, an accepted read returns data on the next cycle
   always @(posedge clk) begin
      if (rst) begin
         rd_ptr <= wr_ptr;
      end else if (fifo_re && fifo_rrdy) begin
         fifo_dout <= mem[rd_ptr % 64];
         rd_ptr    <= rd_ptr + 1;
         rd_count  <= rd_count + 1;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [DW-1:0] w);
      mem[wr_ptr % 64] = w;
      wr_ptr = wr_ptr + 1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic waitValid(input string tag, input int max_cycles);
      int n;
      n = 0;
      while (!m_valid && n < max_cycles) begin
         step();
         n++;
      end
      checkOutput({tag, "_valid"}, 32'(m_valid), 32'd1);
   endtask

   initial begin
      logic          re_h [0:9];
      logic          v_h  [0:9];
      logic [31:0]   d_h  [0:9];
      logic [CW-1:0] c_h  [0:9];
      logic [31:0]   got  [0:2];
      int            run;
      int            n;
      logic          any_v;

      step();
      step();
      applyStimulus(8'hEE);
      fifo_en = 1'b1;
      #1;
      checkOutput("rst_re", 32'(fifo_re), 32'd0);
      checkOutput("rst_valid", 32'(m_valid), 32'd0);
      checkOutput("rst_data", m_data, 32'd0);
      checkOutput("rst_count", 32'(m_count), 32'd0);
      step();
      rst = 1'b0;

      // streaming, downstream always ready
      for (int i = 1; i <= 8; i++) applyStimulus(8'(i * 8'h11));
      #1;
      for (int s = 0; s < 10; s++) begin
         re_h[s] = fifo_re;
         v_h[s]  = m_valid;
         d_h[s]  = m_data;
         c_h[s]  = m_count;
         step();
      end
      run = 0;
      for (int s = 0; s < 8; s++) if (re_h[s]) run++;
      checkOutput("stream_re_run", 32'(run), 32'd8);
      checkOutput("stream_re_after", 32'(re_h[8]), 32'd0);
      checkOutput("stream_lat_v4", 32'(v_h[4]), 32'd0);
      checkOutput("stream_w0_valid", 32'(v_h[5]), 32'd1);
      checkOutput("stream_w0_data", d_h[5], 32'h44332211);
      checkOutput("stream_w0_count", 32'(c_h[5]), 32'd4);
      checkOutput("stream_gap_v6", 32'(v_h[6]), 32'd0);
      checkOutput("stream_w1_valid", 32'(v_h[9]), 32'd1);
      checkOutput("stream_w1_data", d_h[9], 32'h88776655);
      checkOutput("stream_w1_count", 32'(c_h[9]), 32'd4);

      // backpressure: output register plus full accumulator, then reads stop
      m_ready = 1'b0;
      rd0 = rd_count;
      for (int i = 1; i <= 12; i++) applyStimulus(8'(i));
      for (int s = 0; s < 15; s++) step();
      checkOutput("bp_reads", 32'(rd_count - rd0), 32'd8);
      checkOutput("bp_re_low", 32'(fifo_re), 32'd0);
      checkOutput("bp_valid", 32'(m_valid), 32'd1);
      checkOutput("bp_hold_data", m_data, 32'h04030201);
      checkOutput("bp_hold_count", 32'(m_count), 32'd4);
      m_ready = 1'b1;
      n = 0;
      for (int s = 0; s < 20; s++) begin
         if (m_valid && m_ready && n < 3) begin
            got[n] = m_data;
            n++;
         end
         step();
      end
      checkOutput("bp_words", 32'(n), 32'd3);
      if (n == 3) begin
         checkOutput("bp_word1", got[0], 32'h04030201);
         checkOutput("bp_word2", got[1], 32'h08070605);
         checkOutput("bp_word3", got[2], 32'h0C0B0A09);
      end

      // flush of a three-lane partial word, then a single-lane word
      applyStimulus(8'hA1);
      applyStimulus(8'hB2);
      applyStimulus(8'hC3);
      for (int s = 0; s < 6; s++) step();
      checkOutput("fp_no_early", 32'(m_valid), 32'd0);
      flush = 1'b1;
      step();
      flush = 1'b0;
      waitValid("fp3", 10);
      checkOutput("fp3_data", m_data, 32'h00C3B2A1);
      checkOutput("fp3_count", 32'(m_count), 32'd3);
      step();
      checkOutput("fp3_once", 32'(m_valid), 32'd0);
      applyStimulus(8'hD4);
      for (int s = 0; s < 5; s++) step();
      flush = 1'b1;
      step();
      flush = 1'b0;
      waitValid("fp1", 10);
      checkOutput("fp1_data", m_data, 32'h000000D4);
      checkOutput("fp1_count", 32'(m_count), 32'd1);
      step();

      // flush raised while the second read is still in flight
      fifo_en = 1'b0;
      applyStimulus(8'hA1);
      applyStimulus(8'hB2);
      applyStimulus(8'hC3);
      applyStimulus(8'hD4);
      rd0 = rd_count;
      fifo_en = 1'b1;
      step();
      step();
      flush = 1'b1;
      #1;
      checkOutput("fpend_re_gated", 32'(fifo_re), 32'd0);
      step();
      flush = 1'b0;
      waitValid("fpend", 10);
      checkOutput("fpend_data", m_data, 32'h0000B2A1);
      checkOutput("fpend_count", 32'(m_count), 32'd2);
      checkOutput("fpend_reads", 32'(rd_count - rd0), 32'd2);
      step();
      for (int s = 0; s < 8; s++) step();
      flush = 1'b1;
      step();
      flush = 1'b0;
      waitValid("fpend_rest", 10);
      checkOutput("fpend_rest_data", m_data, 32'h0000D4C3);
      checkOutput("fpend_rest_count", 32'(m_count), 32'd2);
      step();

      // flush with an empty accumulator produces nothing
      flush = 1'b1;
      step();
      flush = 1'b0;
      any_v = 1'b0;
      for (int s = 0; s < 6; s++) begin
         if (m_valid) any_v = 1'b1;
         step();
      end
      checkOutput("idle_no_out", 32'(any_v), 32'd0);
      applyStimulus(8'h5A);
      applyStimulus(8'h6B);
      applyStimulus(8'h7C);
      applyStimulus(8'h8D);
      waitValid("idle_next", 12);
      checkOutput("idle_next_data", m_data, 32'h8D7C6B5A);
      checkOutput("idle_next_count", 32'(m_count), 32'd4);
      step();

      // asynchronous reset with a held output word and two lanes filled
      m_ready = 1'b0;
      for (int i = 1; i <= 6; i++) applyStimulus(8'(8'h30 + i));
      for (int s = 0; s < 12; s++) step();
      checkOutput("mrst_pre_valid", 32'(m_valid), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("mrst_valid", 32'(m_valid), 32'd0);
      checkOutput("mrst_data", m_data, 32'd0);
      checkOutput("mrst_count", 32'(m_count), 32'd0);
      step();
      rst = 1'b0;
      m_ready = 1'b1;
      applyStimulus(8'h91);
      applyStimulus(8'h92);
      applyStimulus(8'h93);
      applyStimulus(8'h94);
      waitValid("mrst_new", 12);
      checkOutput("mrst_new_data", m_data, 32'h94939291);
      checkOutput("mrst_new_count", 32'(m_count), 32'd4);
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
